// File: rtl/tmds_multi_encoder.sv
// N-channel TMDS encoder: video (8b/10b with DC balance), control, guard-band and TERC4 coding.
// Two-stage pipeline with clock enable; per-channel running disparity exposed for debug.
module tmds_multi_encoder #(
  parameter int NUM_CH = 3,
  parameter int DISP_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic [1:0]               mode,
  input  logic [8*NUM_CH-1:0]      video_data,
  input  logic [2*NUM_CH-1:0]      ctrl,
  input  logic [4*NUM_CH-1:0]      terc4_data,
  output logic [10*NUM_CH-1:0]     tmds_out,
  output logic [DISP_W*NUM_CH-1:0] disparity
);

  typedef enum logic [1:0] {
    MODE_CTRL   = 2'b00,
    MODE_VIDEO  = 2'b01,
    MODE_GUARD  = 2'b10,
    MODE_ISLAND = 2'b11
  } mode_t;

  localparam logic [DISP_W-1:0] DISP_TWO = DISP_W'(2);

  function automatic logic [3:0] ones8(input logic [7:0] d);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, d[i]};
    return c;
  endfunction

  // Transition-minimising first stage; q[8]=1 marks the XOR chain.
  function automatic logic [8:0] tm_encode(input logic [7:0] d);
    logic [8:0] q;
    logic [3:0] n1;
    logic       use_xnor;
    n1       = ones8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~use_xnor;
    return q;
  endfunction

  function automatic logic [9:0] ctrl_code(input logic [1:0] c);
    logic [9:0] r;
    case (c)
      2'b00:   r = 10'b1101010100;
      2'b01:   r = 10'b0010101011;
      2'b10:   r = 10'b0101010100;
      default: r = 10'b1010101011;
    endcase
    return r;
  endfunction

  function automatic logic [9:0] terc4_code(input logic [3:0] t);
    logic [9:0] r;
    case (t)
      4'h0:    r = 10'b1010011100;
      4'h1:    r = 10'b1001100011;
      4'h2:    r = 10'b1011100100;
      4'h3:    r = 10'b1011100010;
      4'h4:    r = 10'b0101110001;
      4'h5:    r = 10'b0100011110;
      4'h6:    r = 10'b0110001110;
      4'h7:    r = 10'b0100111100;
      4'h8:    r = 10'b1011001100;
      4'h9:    r = 10'b0100111001;
      4'ha:    r = 10'b0110011100;
      4'hb:    r = 10'b1011000110;
      4'hc:    r = 10'b1010001110;
      4'hd:    r = 10'b1001110001;
      4'he:    r = 10'b0101100011;
      default: r = 10'b1011000011;
    endcase
    return r;
  endfunction

  // Mode travels with its payload so a mode switch lands on the output cleanly.
  mode_t                s1_mode;
  logic [2*NUM_CH-1:0]  s1_ctrl;
  logic [4*NUM_CH-1:0]  s1_terc4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_mode  <= MODE_CTRL;
      s1_ctrl  <= '0;
      s1_terc4 <= '0;
    end else if (ce) begin
      s1_mode  <= mode_t'(mode);
      s1_ctrl  <= ctrl;
      s1_terc4 <= terc4_data;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    localparam logic [9:0] GUARD = ((k % 3) == 1) ? 10'b0100110011 : 10'b1011001100;

    logic [8:0]        qm_d;
    logic [3:0]        n1_d;
    logic [8:0]        s1_qm;
    logic [3:0]        s1_n1;
    logic [3:0]        s1_n0;
    logic [9:0]        code_d;
    logic [9:0]        code_q;
    logic [DISP_W-1:0] disp_d;
    logic [DISP_W-1:0] disp_q;
    logic [DISP_W-1:0] n1_w;
    logic [DISP_W-1:0] n0_w;
    logic              disp_neg;
    logic              disp_pos;
    logic              q8;

    assign qm_d = tm_encode(video_data[8*k +: 8]);
    assign n1_d = ones8(qm_d[7:0]);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_qm <= '0;
        s1_n1 <= '0;
        s1_n0 <= '0;
      end else if (ce) begin
        s1_qm <= qm_d;
        s1_n1 <= n1_d;
        s1_n0 <= 4'd8 - n1_d;
      end
    end

    assign n1_w     = {{(DISP_W-4){1'b0}}, s1_n1};
    assign n0_w     = {{(DISP_W-4){1'b0}}, s1_n0};
    assign disp_neg = disp_q[DISP_W-1];
    assign disp_pos = !disp_q[DISP_W-1] && (disp_q != '0);
    assign q8       = s1_qm[8];

    // Any non-video code resets the running disparity.
    always_comb begin
      code_d = '0;
      disp_d = '0;
      case (s1_mode)
        MODE_CTRL:   code_d = ctrl_code(s1_ctrl[2*k +: 2]);
        MODE_GUARD:  code_d = GUARD;
        MODE_ISLAND: code_d = terc4_code(s1_terc4[4*k +: 4]);
        default: begin
          if ((disp_q == '0) || (s1_n1 == s1_n0)) begin
            code_d = {~q8, q8, (q8 ? s1_qm[7:0] : ~s1_qm[7:0])};
            disp_d = q8 ? (disp_q + n1_w - n0_w) : (disp_q + n0_w - n1_w);
          end else if ((disp_pos && (s1_n1 > s1_n0)) || (disp_neg && (s1_n0 > s1_n1))) begin
            code_d = {1'b1, q8, ~s1_qm[7:0]};
            disp_d = disp_q + n0_w - n1_w + (q8 ? DISP_TWO : '0);
          end else begin
            code_d = {1'b0, q8, s1_qm[7:0]};
            disp_d = disp_q + n1_w - n0_w - (q8 ? '0 : DISP_TWO);
          end
        end
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        code_q <= '0;
        disp_q <= '0;
      end else if (ce) begin
        code_q <= code_d;
        disp_q <= disp_d;
      end
    end

    assign tmds_out[10*k +: 10]         = code_q;
    assign disparity[DISP_W*k +: DISP_W] = disp_q;
  end

endmodule

// File: tb/tb_tmds_multi_encoder.sv
// Directed and model-checked bench for tmds_multi_encoder (3 channels, 5-bit disparity).
module tb_tmds_multi_encoder;
  localparam int NUM_CH = 3;
  localparam int DISP_W = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic [23:0] video_data = '0;
  logic [5:0]  ctrl = '0;
  logic [11:0] terc4_data = '0;
  logic [29:0] tmds_out;
  logic [14:0] disparity;

  int n_assert = 0;
  int n_fail = 0;

  tmds_multi_encoder #(.NUM_CH(NUM_CH), .DISP_W(DISP_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .mode       (mode),
    .video_data (video_data),
    .ctrl       (ctrl),
    .terc4_data (terc4_data),
    .tmds_out   (tmds_out),
    .disparity  (disparity)
  );

  always #5 clk = ~clk;

  logic [9:0] ctrl_tab [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  logic [9:0] terc4_tab [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

  localparam logic [9:0] V00_A = 10'b0100000000;
  localparam logic [9:0] V00_B = 10'b1111111111;
  localparam logic [9:0] CTL0  = 10'b1101010100;

  int md [3];

  task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task tick;
    @(posedge clk);
    #1;
  endtask

  task set_in(input logic [1:0] m, input logic [7:0] d, input logic [1:0] c, input logic [3:0] t);
    mode       = m;
    video_data = {3{d}};
    ctrl       = {3{c}};
    terc4_data = {3{t}};
  endtask

  task automatic model_ch(input int k, input logic [1:0] m, input logic [7:0] d,
                          input logic [1:0] c, input logic [3:0] t, output logic [9:0] code);
    int ones, n1, n0;
    logic xn, q8;
    logic [7:0] q;
    case (m)
      2'b00: begin code = ctrl_tab[c]; md[k] = 0; end
      2'b10: begin code = ((k % 3) == 1) ? 10'b0100110011 : 10'b1011001100; md[k] = 0; end
      2'b11: begin code = terc4_tab[t]; md[k] = 0; end
      default: begin
        ones = $countones(d);
        xn   = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = xn ? (q[i-1] ~^ d[i]) : (q[i-1] ^ d[i]);
        q8 = !xn;
        n1 = $countones(q);
        n0 = 8 - n1;
        if (md[k] == 0 || n1 == n0) begin
          code = {~q8, q8, (q8 ? q : ~q)};
          md[k] = md[k] + (q8 ? (n1 - n0) : (n0 - n1));
        end else if ((md[k] > 0 && n1 > n0) || (md[k] < 0 && n0 > n1)) begin
          code = {1'b1, q8, ~q};
          md[k] = md[k] + (q8 ? 2 : 0) + n0 - n1;
        end else begin
          code = {1'b0, q8, q};
          md[k] = md[k] + n1 - n0 - (q8 ? 0 : 2);
        end
      end
    endcase
  endtask

  logic [1:0]  p_mode;
  logic [23:0] p_vd;
  logic [5:0]  p_ctrl;
  logic [11:0] p_t4;
  logic [29:0] exp_out;
  logic [14:0] exp_disp;
  logic [9:0]  code;
  int          max_abs;

  initial begin
    // reset state
    @(posedge clk);
    #1;
    chk("rst_out", 32'(tmds_out), 32'h0);
    chk("rst_disp", 32'(disparity), 32'h0);
    #2 rst = 1'b0;

    // control codes on ch0, ch1 pinned to ctrl=11
    mode = 2'b00;
    ctrl = {2'b00, 2'b11, 2'b00};
    tick;
    ctrl = {2'b00, 2'b11, 2'b01};
    tick;
    chk("ctrl00", 32'(tmds_out[9:0]), 32'(10'b1101010100));
    chk("ctrl_ch1", 32'(tmds_out[19:10]), 32'(10'b1010101011));
    ctrl = {2'b00, 2'b11, 2'b10};
    tick;
    chk("ctrl01", 32'(tmds_out[9:0]), 32'(10'b0010101011));
    ctrl = {2'b00, 2'b11, 2'b11};
    tick;
    chk("ctrl10", 32'(tmds_out[9:0]), 32'(10'b0101010100));
    tick;
    chk("ctrl11", 32'(tmds_out[9:0]), 32'(10'b1010101011));
    chk("ctrl_disp", 32'(disparity), 32'h0);

    // video 0x00 x3 from D=0
    set_in(2'b01, 8'h00, 2'b00, 4'h0);
    tick;
    tick;
    chk("v0_code", 32'(tmds_out), 32'({3{V00_A}}));
    chk("v0_disp", 32'(disparity), 32'({3{5'b11000}}));
    tick;
    chk("v1_code", 32'(tmds_out), 32'({3{V00_B}}));
    chk("v1_disp", 32'(disparity), 32'({3{5'b00010}}));
    tick;
    chk("v2_code", 32'(tmds_out), 32'({3{V00_A}}));
    chk("v2_disp", 32'(disparity), 32'({3{5'b11010}}));

    // same stream with ce gaps
    set_in(2'b00, 8'h00, 2'b00, 4'h0);
    tick;
    tick;
    set_in(2'b01, 8'h00, 2'b00, 4'h0);
    tick;
    ce = 1'b0;
    repeat (3) tick;
    chk("ce_hold_ctl", 32'(tmds_out), 32'({3{CTL0}}));
    ce = 1'b1;
    tick;
    chk("ce_v0_code", 32'(tmds_out), 32'({3{V00_A}}));
    ce = 1'b0;
    repeat (3) tick;
    chk("ce_hold_v0", 32'(tmds_out), 32'({3{V00_A}}));
    chk("ce_hold_d0", 32'(disparity), 32'({3{5'b11000}}));
    ce = 1'b1;
    tick;
    chk("ce_v1_code", 32'(tmds_out), 32'({3{V00_B}}));
    chk("ce_v1_disp", 32'(disparity), 32'({3{5'b00010}}));
    ce = 1'b0;
    repeat (3) tick;
    chk("ce_hold_v1", 32'(tmds_out), 32'({3{V00_B}}));
    ce = 1'b1;
    tick;
    chk("ce_v2_code", 32'(tmds_out), 32'({3{V00_A}}));
    chk("ce_v2_disp", 32'(disparity), 32'({3{5'b11010}}));

    // video -> TERC4 0x5 -> video
    set_in(2'b00, 8'h00, 2'b00, 4'h0);
    tick;
    tick;
    set_in(2'b01, 8'h00, 2'b00, 4'h0);
    tick;
    set_in(2'b11, 8'h00, 2'b00, 4'h5);
    tick;
    chk("isl_pre_code", 32'(tmds_out), 32'({3{V00_A}}));
    set_in(2'b01, 8'h00, 2'b00, 4'h0);
    tick;
    chk("isl_code", 32'(tmds_out), 32'({3{10'b0100011110}}));
    chk("isl_disp", 32'(disparity), 32'h0);
    tick;
    chk("isl_post_code", 32'(tmds_out), 32'({3{V00_A}}));
    chk("isl_post_disp", 32'(disparity), 32'({3{5'b11000}}));

    // guard band rows
    set_in(2'b10, 8'h00, 2'b00, 4'h0);
    tick;
    tick;
    chk("guard", 32'(tmds_out), 32'({10'b1011001100, 10'b0100110011, 10'b1011001100}));
    chk("guard_disp", 32'(disparity), 32'h0);

    // asynchronous reset mid-stream
    set_in(2'b01, 8'h00, 2'b00, 4'h0);
    tick;
    tick;
    tick;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out", 32'(tmds_out), 32'h0);
    chk("mid_rst_disp", 32'(disparity), 32'h0);
    #2 rst = 1'b0;
    tick;
    chk("post_rst_ctl", 32'(tmds_out), 32'({3{CTL0}}));
    tick;
    chk("post_rst_vid", 32'(tmds_out), 32'({3{V00_A}}));
    chk("post_rst_disp", 32'(disparity), 32'({3{5'b11000}}));

    // random traffic against the model
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    p_mode = '0; p_vd = '0; p_ctrl = '0; p_t4 = '0;
    exp_out = '0; exp_disp = '0;
    for (int k = 0; k < 3; k++) md[k] = 0;
    max_abs = 0;
    for (int it = 0; it < 6000; it++) begin
      ce         = ($urandom_range(0, 9) < 8);
      mode       = ($urandom_range(0, 9) < 8) ? 2'b01 : 2'($urandom_range(0, 3));
      video_data = 24'($urandom);
      ctrl       = 6'($urandom);
      terc4_data = 12'($urandom);
      tick;
      if (ce) begin
        for (int k = 0; k < 3; k++) begin
          model_ch(k, p_mode, p_vd[8*k +: 8], p_ctrl[2*k +: 2], p_t4[4*k +: 4], code);
          exp_out[10*k +: 10] = code;
          exp_disp[5*k +: 5]  = 5'(md[k]);
          if (md[k] > max_abs) max_abs = md[k];
          if (-md[k] > max_abs) max_abs = -md[k];
        end
        p_mode = mode; p_vd = video_data; p_ctrl = ctrl; p_t4 = terc4_data;
      end
      chk("rnd_code", 32'(tmds_out), 32'(exp_out));
      chk("rnd_disp", 32'(disparity), 32'(exp_disp));
    end
    chk("disp_bound", 32'(max_abs <= 10), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
